// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, 16x oversampled from the system clock.
// Ports: clk        system clock, rising edge
//        rst        asynchronous active-low reset
//        rx         serial line, idle high, asynchronous to clk
//        data_out   last correctly framed byte, held until the next good frame
//        data_valid one-clk strobe, data_out updated this cycle
//        frame_err  one-clk strobe, stop bit sampled low
//        busy       high whenever the receiver is not idle
// Build option: define UART_RX_MAJORITY_EN to vote each bit over the scnt 7/8/9 samples.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          rx_m_q, rx_s_q, rx_p_q;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]    scnt_q, scnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shift_q, shift_d, dout_q, dout_d;
    logic          dv_q, dv_d, fe_q, fe_d;
    logic          tick, decide, bit_v;

    // dcnt sits at 0 while idle, so no tick can fire there
    assign tick = dcnt_q == DW'(DIV - 1);

`ifdef UART_RX_MAJORITY_EN
    logic s7_q, s8_q;
    assign decide = tick && scnt_q == 4'd9;
    assign bit_v  = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s7_q <= 1'b1;
            s8_q <= 1'b1;
        end else begin
            if (tick && scnt_q == 4'd7) s7_q <= rx_s_q;
            if (tick && scnt_q == 4'd8) s8_q <= rx_s_q;
        end
    end
`else
    assign decide = tick && scnt_q == 4'd8;
    assign bit_v  = rx_s_q;
`endif

    always_comb begin
        state_d = state_q;
        dcnt_d  = tick ? '0 : dcnt_q + 1'b1;
        scnt_d  = tick ? scnt_q + 4'd1 : scnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            IDLE: begin
                dcnt_d = '0;
                scnt_d = '0;
                if (rx_p_q && !rx_s_q) state_d = START;
            end
            START: if (decide) begin
                state_d = bit_v ? IDLE : DATA;
                bidx_d  = 3'd0;
            end
            DATA: if (decide) begin
                shift_d = {bit_v, shift_q[7:1]};
                bidx_d  = bidx_q + 3'd1;
                if (bidx_q == 3'd7) state_d = STOP;
            end
            STOP: if (decide) begin
                state_d = bit_v ? IDLE : BRK;
                dout_d  = bit_v ? shift_q : dout_q;
                dv_d    = bit_v;
                fe_d    = !bit_v;
            end
            BRK: begin
                dcnt_d = '0;
                scnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            state_q <= IDLE;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            rx_p_q  <= rx_s_q;
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIV=10 (160 clk per bit).
module tb_uart_rx;
    typedef struct {
        logic       kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 1543;
    localparam logic [7:0] GLITCH_BYTE = 8'h5A;
`else
    localparam int LAT = 1533;
    localparam logic [7:0] GLITCH_BYTE = 8'h58;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, busy;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       scb[$];

    uart_rx #(.CLK_FREQ(1600000), .BAUD(10000)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind 0 = data_valid, 1 = frame_err; start bit begins one ns after the edge counted in cyc
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit, input logic [7:0] exp_d);
        logic [9:0] f;
        exp_t e;
        f = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        e.kind = !stop;
        e.data = stop ? exp_d : last_good;
        e.cyc  = cyc + LAT;
        scb.push_back(e);
        if (stop) last_good = exp_d;
        for (int k = 0; k < 1600; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            rx = f[k / 160] ^ (gbit >= 0 && k == 90 + 160 * (gbit + 1));
        end
    endtask

    always @(negedge clk) begin
        if (data_valid || frame_err) begin
            check("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
            if (scb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got dv=%0b fe=%0b at cyc %0d expected none", data_valid, frame_err, cyc);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, e.kind});
                check("data_out", {24'd0, data_out}, {24'd0, e.data});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        logic [9:0] f;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(8'hA5, 1'b1, -1, 8'hA5);
        @(negedge clk);
        check("busy_after_a5", {31'd0, busy}, 32'd0);

        send_frame(8'h00, 1'b1, -1, 8'h00);
        send_frame(8'hFF, 1'b1, -1, 8'hFF);
        repeat (20) @(posedge clk);

        @(posedge clk);
        #1 rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        check("busy_in_false_start", {31'd0, busy}, 32'd1);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("busy_after_false_start", {31'd0, busy}, 32'd0);

        send_frame(8'h3C, 1'b0, -1, 8'h3C);
        repeat (480) @(posedge clk);
        @(negedge clk);
        check("busy_in_break", {31'd0, busy}, 32'd1);
        check("data_out_kept", {24'd0, data_out}, 32'h0000_00FF);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("busy_after_break", {31'd0, busy}, 32'd0);
        send_frame(8'h55, 1'b1, -1, 8'h55);
        repeat (20) @(posedge clk);

        f = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            #1 rx = f[k / 160];
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check("midrst_data_out", {24'd0, data_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        last_good = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("postrst_data_out", {24'd0, data_out}, 32'd0);
        send_frame(8'h81, 1'b1, -1, 8'h81);
        repeat (20) @(posedge clk);

        send_frame(8'h5A, 1'b1, 1, GLITCH_BYTE);
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", scb.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1, LSB first; the receive counterpart of the team's UART transmitter.
- Samples the serial line with a 16x oversampling tick derived from the system clock.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the byte-consuming logic (command decoder / loopback checker).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- DIV, CLK_FREQ/(BAUD*16), clocks per oversample tick (integer, truncated); must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last correctly framed byte; holds until next good frame.
- data_valid  output  1  one-clk pulse, data_out updated this cycle.
- frame_err  output  1  one-clk pulse, stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, data_out=8'h00, data_valid=0, frame_err=0, busy=0, all counters 0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only; 2-clk input latency.
- Tick generator: counter 0..DIV-1, tick=1 for one clk when counter==DIV-1; held at 0 in IDLE, restarted at 0 on start-edge detection.
- Sample counter scnt 0..15, advances on tick, wraps 15->0; one full wrap = one bit period.
- States:
- IDLE: wait for rx_s==0 (registered falling edge: previous rx_s=1, current rx_s=0) -> START, clear tick and scnt.
- START: at decision point, if sampled value==1, it is a false start -> IDLE with no output pulse. Else -> DATA, bit index=0.
- DATA: at each decision point shift the sampled bit into shift_reg[7] (right shift, LSB first). After bit index 7 -> STOP.
- STOP: at the decision point, if sampled 1 -> data_out<=shift_reg, data_valid=1 for the next clk -> IDLE. If sampled 0 -> frame_err=1 for one clk, data_out unchanged -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. No edge detection or output pulses while in BREAK.
- Decision point: the tick on which scnt==8 (mid-bit); each subsequent bit is decided exactly 16 ticks later.
- data_valid and frame_err never assert in the same cycle; each is exactly 1 clk wide.
- data_valid asserts 1 clk after the stop-bit decision tick.
- Back-to-back frames: a start edge arriving any time after returning to IDLE is accepted; there is no stop-bit dwell requirement beyond the mid-stop decision.
- Reset asserted mid-frame: the partial byte is discarded, no pulse is issued, data_out returns to 0.
- Glitch on an idle line shorter than half a bit: rejected by the START check.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit is sampled on the ticks with scnt==7, 8 and 9. The bit value is the majority of the three, and the decision is taken on the scnt==9 tick, so all decisions (start check, data, stop) and data_valid/frame_err move 1 tick later.
- Undefined: single sample on the scnt==8 tick as described above; no extra sample registers.

Test Plan (CLK_FREQ=1600000, BAUD=10000 -> DIV=10, 160 clk/bit):
- Reset, then send 8'hA5 8N1 -> exactly one data_valid pulse, data_out==8'hA5, frame_err never high, busy low afterwards.
- Send 8'h00 then 8'hFF back-to-back with a 1-bit stop -> two data_valid pulses, in order 8'h00 then 8'hFF.
- Drive rx low for 40 clk on an idle line -> no data_valid or frame_err pulse; state back in IDLE (busy=0) within 100 clk.
- Send 8'h3C with the stop bit driven low, hold rx low 3 more bit times, then raise it -> one frame_err pulse, data_out keeps its previous value, no start accepted until rx is high; a following 8'h55 is received correctly.
- Assert rst mid-byte (after 4 data bits of 8'hC3), release it, then send 8'h81 -> no pulse for the aborted frame; data_out==8'h00 after reset; 8'h81 is then received.
- With UART_RX_MAJORITY_EN: send 8'h5A with a 1-clk low glitch injected at scnt==8 of a '1' data bit -> data_out==8'h5A; data_valid arrives DIV clk later than in the non-macro build.
